// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader and the instruction-memory write port.
package program_loader_pkg;

    localparam int unsigned PROG_AW = 8;
    localparam int unsigned PROG_DW = 16;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control of the loader.
interface program_loader_if;

    logic [7:0]                              rx_data;
    logic                                    rx_valid;
    logic                                    rx_ready;
    logic                                    program_write;
    logic [program_loader_pkg::PROG_AW-1:0]  program_address;
    logic [program_loader_pkg::PROG_DW-1:0]  program_data;
    logic                                    cpu_reset;
    logic                                    busy;
    logic                                    done;
    logic                                    error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, program_write, program_address, program_data,
        output cpu_reset, busy, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, program_write, program_address, program_data,
        input  cpu_reset, busy, done, error
    );

endinterface

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: assembles 16-bit words, writes them to the
// instruction memory, validates the checksum and holds the CPU in reset meanwhile.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] TIMEOUT       = 16'd50000,
    parameter logic        HOLD_ON_RESET = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.master bus
);

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [7:0]         r_sum;
    logic [8:0]         r_words;
    logic [15:0]        r_idle;
    logic [PROG_AW-1:0] r_addr;
    logic [PROG_DW-1:0] r_data;
    logic               r_cpu_reset;
    logic               r_error;

    logic w_rx_ready;
    logic w_accept;
    logic w_is_header;
    logic w_timed;
    logic w_timeout;
    logic w_write;
    logic w_done;
    logic w_busy;

    // Ready depends on state only, so accept can feed next-state logic without a loop.
    always_comb begin
        w_rx_ready = 1'b1;
        case (r_state)
            ST_WRITE, ST_DONE, ST_ERROR: w_rx_ready = 1'b0;
            default:                     w_rx_ready = 1'b1;
        endcase
    end

    assign w_accept    = bus.rx_valid && w_rx_ready;
    assign w_is_header = (bus.rx_data == LOADER_HEADER);
    assign w_timed     = (r_state == ST_COUNT) || (r_state == ST_HI) ||
                         (r_state == ST_LO)    || (r_state == ST_CHECK);

    // Fires on the edge where the idle count would reach TIMEOUT with no byte arriving.
    assign w_timeout   = (TIMEOUT != '0) && w_timed && !w_accept &&
                         ((r_idle + 16'd1) == TIMEOUT);

    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_done  = 1'b0;
        w_busy  = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_header) w_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_timeout)     w_next = ST_ERROR;
                else if (w_accept) w_next = ST_HI;
            end
            ST_HI: begin
                if (w_timeout)     w_next = ST_ERROR;
                else if (w_accept) w_next = ST_LO;
            end
            ST_LO: begin
                if (w_timeout)     w_next = ST_ERROR;
                else if (w_accept) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_write = 1'b1;
                w_next  = (r_words == 9'd1) ? ST_CHECK : ST_HI;
            end
            ST_CHECK: begin
                if (w_timeout)     w_next = ST_ERROR;
                else if (w_accept) w_next = (bus.rx_data == r_sum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERROR: begin
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_words     <= '0;
            r_idle      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_cpu_reset <= HOLD_ON_RESET;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept)     r_idle <= '0;
            else if (w_timed) r_idle <= r_idle + 16'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_header) begin
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_addr      <= '0;
                        r_sum       <= '0;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        // A count of 0 means 256 words.
                        r_words <= {bus.rx_data == 8'd0, bus.rx_data};
                        r_sum   <= r_sum + bus.rx_data;
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        r_data[15:8] <= bus.rx_data;
                        r_sum        <= r_sum + bus.rx_data;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_data[7:0] <= bus.rx_data;
                        r_sum       <= r_sum + bus.rx_data;
                    end
                end
                ST_WRITE: begin
                    r_addr  <= r_addr + 8'd1;
                    r_words <= r_words - 9'd1;
                end
                ST_CHECK: begin
                    if (w_accept && (bus.rx_data != r_sum)) r_error <= 1'b1;
                end
                ST_DONE: begin
                    r_cpu_reset <= 1'b0;
                end
                default: ;
            endcase

            if (w_timeout) r_error <= 1'b1;
        end
    end

    assign bus.rx_ready        = w_rx_ready;
    assign bus.program_write   = w_write;
    assign bus.program_address = r_addr;
    assign bus.program_data    = r_data;
    assign bus.cpu_reset       = r_cpu_reset;
    assign bus.busy            = w_busy;
    assign bus.done            = w_done;
    assign bus.error           = r_error;

endmodule
